// File: rtl/muldiv_unit.sv
// Iterative 32-iteration multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_DIVZERO_EN: early div_zero completion for division by zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
`ifdef MULDIV_DIVZERO_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DZ} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mpl;
  logic [WIDTH-1:0] a_raw;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] mpl_n;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;
  logic             signed_op;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v,
                                             input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign signed_op = ~op[0];

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, mcand};
    shifted = {acc, mpl[WIDTH-1]};
    diff    = shifted - {1'b0, mcand};
    acc_n   = acc;
    mpl_n   = mpl;
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_n = diff[WIDTH-1:0];
        mpl_n = {mpl[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted[WIDTH-1:0];
        mpl_n = {mpl[WIDTH-2:0], 1'b0};
      end
    end else if (mpl[0]) begin
      {acc_n, mpl_n} = {sum, mpl[WIDTH-1:1]};
    end else begin
      {acc_n, mpl_n} = {1'b0, acc, mpl[WIDTH-1:1]};
    end
  end

  // Sign correction on the final iteration's raw magnitudes
  always_comb begin
    hi_res = '0;
    lo_res = '0;
    if (is_div) begin
      if (b_zero) begin
        lo_res = '1;
        hi_res = a_raw;
      end else begin
        lo_res = neg_w(mpl_n, neg_q);
        hi_res = neg_w(acc_n, neg_r);
      end
    end else begin
      {hi_res, lo_res} = neg_dw({acc_n, mpl_n}, neg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      mpl      <= '0;
      a_raw    <= '0;
      HI       <= '0;
      LO       <= '0;
`ifdef MULDIV_DIVZERO_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      div_zero <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div <= op[1];
            mcand  <= abs_w(B, signed_op);
            mpl    <= abs_w(A, signed_op);
            acc    <= '0;
            cnt    <= '0;
            a_raw  <= A;
            b_zero <= (B == '0);
            neg_q  <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= signed_op & A[WIDTH-1];
            busy   <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
            state  <= (op[1] && (B == '0)) ? S_DZ : S_RUN;
`else
            state  <= S_RUN;
`endif
          end else begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
          end
        end
        S_RUN: begin
          acc <= acc_n;
          mpl <= mpl_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            HI    <= hi_res;
            LO    <= lo_res;
          end
        end
`ifdef MULDIV_DIVZERO_EN
        S_DZ: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= 1'b1;
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, ignored inputs while busy,
// mthi/mtlo, divide-by-zero (both builds via MULDIV_DIVZERO_EN) and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] HI, LO;
`ifdef MULDIV_DIVZERO_EN
  logic        div_zero;
`endif

  int tests = 0;
  int fails = 0;
  int n;
  logic seen;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
`ifdef MULDIV_DIVZERO_EN
    .div_zero(div_zero),
`endif
    .HI(HI), .LO(LO)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch_now(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    launch_now(o, a, b);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);

    // multu max*max
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", busy, 1);
    wait_done(n);
    check("multu_latency", n, 32);
    check("multu_done_busy", busy, 0);
    check("multu_hi", HI, 64'hFFFF_FFFE);
    check("multu_lo", LO, 64'h0000_0001);

    // start accepted in the done cycle: mult -3*5
    launch_now(2'b00, 32'hFFFF_FFFD, 32'd5);
    check("b2b_busy", busy, 1);
    check("b2b_done_gone", done, 0);
    wait_done(n);
    check("mult_neg_latency", n, 32);
    check("mult_neg_hi", HI, 64'hFFFF_FFFF);
    check("mult_neg_lo", LO, 64'hFFFF_FFF1);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    launch(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    check("mult_min_hi", HI, 64'h4000_0000);
    check("mult_min_lo", LO, 64'h0);

    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("div_neg_latency", n, 32);
    check("div_neg_lo", LO, 64'hFFFF_FFFD);
    check("div_neg_hi", HI, 64'hFFFF_FFFF);

    launch(2'b11, 32'd100, 32'd7);
    wait_done(n);
    check("divu_lo", LO, 64'h0000_000E);
    check("divu_hi", HI, 64'h0000_0002);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("div_wrap_lo", LO, 64'h8000_0000);
    check("div_wrap_hi", HI, 64'h0);

    // multu 6*7 with a new start at iteration 10 and mthi at iteration 20
    launch(2'b01, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b01; A = 32'd100; B = 32'd100;
    @(negedge clk);
    start = 1'b0;
    check("intf_busy", busy, 1);
    repeat (9) @(negedge clk);
    hi_we = 1'b1; wdata = 32'hFFFF;
    @(negedge clk);
    hi_we = 1'b0;
    wait_done(n);
    check("intf_latency", n, 12);
    check("intf_hi", HI, 64'h0);
    check("intf_lo", LO, 64'd42);

    // mthi when idle
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", HI, 64'h1234);
    check("mthi_lo", LO, 64'd42);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_hi", HI, 64'hCAFE);
    check("mthilo_lo", LO, 64'hCAFE);

    // start wins over mthi in the same cycle
    hi_we = 1'b1; wdata = 32'hDEAD;
    launch_now(2'b01, 32'd2, 32'd3);
    hi_we = 1'b0;
    check("start_wins_hi", HI, 64'hCAFE);
    check("start_wins_busy", busy, 1);
    wait_done(n);
    check("start_wins_lat", n, 32);
    check("start_wins_res_hi", HI, 64'h0);
    check("start_wins_res_lo", LO, 64'd6);

    // divu by zero
    launch(2'b11, 32'd9, 32'd0);
    check("dz_busy", busy, 1);
    wait_done(n);
`ifdef MULDIV_DIVZERO_EN
    check("dz_latency", n, 1);
    check("dz_flag", div_zero, 1);
    check("dz_busy_after", busy, 0);
    check("dz_hi", HI, 64'h0);
    check("dz_lo", LO, 64'd6);
    @(negedge clk);
    check("dz_flag_pulse", div_zero, 0);
`else
    check("dz_latency", n, 32);
    check("dz_hi", HI, 64'd9);
    check("dz_lo", LO, 64'hFFFF_FFFF);
`endif

    // reset at iteration 15 of a div
    launch(2'b10, 32'd1000, 32'd3);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_hi", HI, 64'h0);
    check("midrst_lo", LO, 64'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);

    launch(2'b11, 32'd100, 32'd7);
    wait_done(n);
    check("post_rst_latency", n, 32);
    check("post_rst_lo", LO, 64'h0000_000E);
    check("post_rst_hi", HI, 64'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits beside the ALU, directly upstream of the register file write-data mux; mfhi/mflo results reach RegFile Write_data through HI/LO.
- Control stalls the PC while busy is high.
- Executes mult/multu/div/divu over 32 iterations; supports mthi/mtlo direct writes.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  launch operation; sampled only when busy=0.
op  input  2  00 mult, 01 multu, 10 div, 11 divu.
A  input  WIDTH  rs operand (multiplicand / dividend).
B  input  WIDTH  rt operand (multiplier / divisor).
hi_we  input  1  mthi: HI <= wdata.
lo_we  input  1  mtlo: LO <= wdata.
wdata  input  WIDTH  mthi/mtlo data.
busy  output  1  operation in flight.
done  output  1  one-cycle pulse; HI/LO hold new result.
HI  output  WIDTH  HI register (product upper half / remainder).
LO  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: busy=0, done=0, HI=0, LO=0, internal state cleared. Reset mid-operation aborts it; HI/LO go to 0 and no done pulse follows.
- FSM states:
  - IDLE: start=1 at edge E0 latches magnitudes of A/B (signed ops: two's-complement abs), result signs and op, clears the accumulator, then moves to RUN. busy=1 from E0.
  - RUN: one iteration per edge, counter 0..WIDTH-1.
    - Multiply: shift-add over 64-bit {acc,mplier}.
    - Divide: restoring shift-subtract producing one quotient bit per edge.
  - At edge E32 (last iteration), sign correction is applied combinationally and HI/LO are written.
    - Multiply: {HI,LO} = product, negated if sign(A)^sign(B) for mult.
    - Divide: LO = quotient, negated if sign(A)^sign(B); HI = remainder, sign of A (div only).
  - After E32: FSM goes to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: start at E0 -> results and done after E32. start may be reasserted in the done cycle and is accepted.
- start while busy=1: ignored, no queueing.
- hi_we/lo_we:
  - Take effect at the next edge only when busy=0 and start=0.
  - Ignored while busy.
  - If start=1 in the same cycle, start wins and the write is dropped.
  - hi_we and lo_we together write both registers.
- Signed corner case: -2^31 / -1 gives LO=0x80000000, HI=0 (wrap, no trap). Multiply never overflows.
- HI/LO are stable outputs and change only at reset, final iteration, or mthi/mtlo.

Optional Feature:
Macro MULDIV_DIVZERO_EN.
- Defined:
  - Adds output div_zero (1 bit, reset 0).
  - div/divu with B=0 skips RUN; done and div_zero pulse together one cycle after E0.
  - busy is high for that single cycle; HI/LO are unchanged.
- Undefined:
  - No div_zero port.
  - B=0 runs the full 32 iterations; result forced to LO=0xFFFFFFFF, HI=A (raw operand) for both div and divu.

Test Plan:
- multu A=0xFFFFFFFF B=0xFFFFFFFF -> busy 32 cycles, done pulse, HI=0xFFFFFFFE LO=0x00000001.
- mult A=-3 (0xFFFFFFFD) B=5 -> HI=0xFFFFFFFF LO=0xFFFFFFF1. mult A=0x80000000 B=0x80000000 -> HI=0x40000000 LO=0.
- div A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=100 B=7 -> LO=0x0000000E, HI=0x00000002. div A=0x80000000 B=-1 -> LO=0x80000000 HI=0.
- Start multu 6*7; pulse start with new operands at iteration 10; assert hi_we at iteration 20 -> both ignored, result HI=0 LO=42. Then hi_we wdata=0x1234 with busy=0 -> HI=0x1234 next edge.
- divu A=9 B=0 -> with MULDIV_DIVZERO_EN: done and div_zero after 1 cycle, HI/LO unchanged. Without it: done after 32 cycles, LO=0xFFFFFFFF HI=9.
- Assert reset at iteration 15 of div -> busy=0, HI=LO=0, no done pulse. A new start after reset completes normally.
